// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 stream demultiplexer
package demux_pkg;
  localparam int NUM_OUT = 4;
  typedef logic [1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output holding register with its beat counter
module demux_slot #(
  parameter int N       = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [N-1:0]       in_data,
  input  logic               out_ready,
  output logic [N-1:0]       data,
  output logic               valid,
  output logic [COUNT_W-1:0] cnt,
  output logic               ready
);
  logic [N-1:0]       data_q, data_d;
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               drain;
  assign drain = valid_q && out_ready;
  // A load on the draining edge replaces the beat, keeping valid high
  always_comb begin
    data_d  = load ? in_data : data_q;
    valid_d = load || (valid_q && !out_ready);
    cnt_d   = cnt_q + COUNT_W'(drain);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign data  = data_q;
  assign valid = valid_q;
  assign cnt   = cnt_q;
  assign ready = !valid_q || out_ready;
endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 valid/ready stream demultiplexer
module demux4_stream
  import demux_pkg::*;
#(
  parameter int N       = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N-1:0]       out_0,
  output logic [N-1:0]       out_1,
  output logic [N-1:0]       out_2,
  output logic [N-1:0]       out_3,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [COUNT_W-1:0] cnt_0,
  output logic [COUNT_W-1:0] cnt_1,
  output logic [COUNT_W-1:0] cnt_2,
  output logic [COUNT_W-1:0] cnt_3
);
  logic [NUM_OUT-1:0] load, ready;
  logic [N-1:0]       data [NUM_OUT];
  logic [COUNT_W-1:0] cnt [NUM_OUT];
  // Only the selected slot gates acceptance, so a stalled output never blocks others
  assign in_ready = rst_n && ready[in_sel];
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    assign load[k] = in_valid && in_ready && (in_sel == sel_t'(k));
    demux_slot #(.N(N), .COUNT_W(COUNT_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .data      (data[k]),
      .valid     (out_valid[k]),
      .cnt       (cnt[k]),
      .ready     (ready[k])
    );
  end
  assign out_0 = data[0];
  assign out_1 = data[1];
  assign out_2 = data[2];
  assign out_3 = data[3];
  assign cnt_0 = cnt[0];
  assign cnt_1 = cnt[1];
  assign cnt_2 = cnt[2];
  assign cnt_3 = cnt[3];
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: scoreboard bench for demux4_stream, plus a narrow-counter build for wrap
module tb_demux4_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_0, out_1, out_2, out_3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [15:0] cnt_0, cnt_1, cnt_2, cnt_3;
  logic [7:0]  w_in_data = '0;
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [7:0]  w_out_0, w_out_1, w_out_2, w_out_3;
  logic [3:0]  w_out_valid;
  logic [3:0]  w_out_ready = '0;
  logic [3:0]  w_cnt_0, w_cnt_1, w_cnt_2, w_cnt_3;
  int checks = 0;
  int failures = 0;
  logic [7:0]  q [4][$];
  logic [15:0] exp_cnt [4];
  logic [7:0]  outs [4];
  logic [15:0] cnts [4];

  always #5 clk = ~clk;

  demux4_stream #(.N(8), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
  );

  demux4_stream #(.N(8), .COUNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(w_in_data), .in_sel(2'd1), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .out_0(w_out_0), .out_1(w_out_1), .out_2(w_out_2), .out_3(w_out_3),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .cnt_0(w_cnt_0), .cnt_1(w_cnt_1), .cnt_2(w_cnt_2), .cnt_3(w_cnt_3)
  );

  assign outs = '{out_0, out_1, out_2, out_3};
  assign cnts = '{cnt_0, cnt_1, cnt_2, cnt_3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      exp_cnt[k] = '0;
    end
  endtask

  // Negedge monitor: verify current state, then apply the handshakes of the coming edge
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
        check($sformatf("cnt%0d", k), 32'(cnts[k]), 32'(exp_cnt[k]));
        if (out_valid[k] && q[k].size() != 0)
          check($sformatf("data%0d", k), 32'(outs[k]), 32'(q[k][0]));
      end
      if (in_valid)
        check("in_ready", 32'(in_ready), 32'(q[in_sel].size() == 0 || out_ready[in_sel]));
      for (int k = 0; k < 4; k++)
        if (out_valid[k] && out_ready[k] && q[k].size() != 0) begin
          void'(q[k].pop_front());
          exp_cnt[k] = exp_cnt[k] + 16'd1;
        end
      if (in_valid && in_ready) q[in_sel].push_back(in_data);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = '0;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Leaves in_valid high after acceptance so back-to-back sends stream at full rate
  task automatic send(input logic [1:0] sel, input logic [7:0] data);
    bit ok;
    in_sel = sel;
    in_data = data;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clear_model();
    #2;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_cnt0", 32'(cnt_0), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(2'd1, 8'h34);
    idle();
    check("t1_valid", 32'(out_valid), 32'h2);
    check("t1_out1", 32'(out_1), 32'h34);
    tick(10);
    check("t1_hold_valid", 32'(out_valid), 32'h2);
    check("t1_hold_out1", 32'(out_1), 32'h34);
    check("t1_cnt1", 32'(cnt_1), 32'h0);

    do_reset();
    send(2'd0, 8'h00);
    send(2'd1, 8'hA1);
    send(2'd2, 8'hF2);
    send(2'd3, 8'h33);
    idle();
    check("sweep_valid", 32'(out_valid), 32'hF);
    check("sweep_out0", 32'(out_0), 32'h00);
    check("sweep_out1", 32'(out_1), 32'hA1);
    check("sweep_out2", 32'(out_2), 32'hF2);
    check("sweep_out3", 32'(out_3), 32'h33);
    out_ready = 4'hF;
    tick(1);
    check("sweep_drained", 32'(out_valid), 32'h0);
    check("sweep_cnts", {cnt_0[7:0], cnt_1[7:0], cnt_2[7:0], cnt_3[7:0]}, 32'h01010101);

    out_ready = 4'h0;
    send(2'd2, 8'h5C);
    in_sel = 2'd2;
    in_data = 8'hFF;
    in_valid = 1'b1;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h0);
    tick(3);
    check("bp_out2", 32'(out_2), 32'h5C);
    check("bp_in_ready_held", 32'(in_ready), 32'h0);
    send(2'd3, 8'h13);
    idle();
    check("bp_out3", 32'(out_3), 32'h13);
    check("bp_out2_kept", 32'(out_2), 32'h5C);
    check("bp_valid", 32'(out_valid), 32'hC);

    do_reset();
    out_ready = 4'b0001;
    send(2'd0, 8'h65);
    check("st_out0_a", 32'(out_0), 32'h65);
    send(2'd0, 8'hB1);
    check("st_out0_b", 32'(out_0), 32'hB1);
    send(2'd0, 8'hE2);
    check("st_out0_c", 32'(out_0), 32'hE2);
    send(2'd0, 8'h0C);
    check("st_out0_d", 32'(out_0), 32'h0C);
    idle();
    tick(1);
    check("st_cnt0", 32'(cnt_0), 32'h4);
    check("st_valid", 32'(out_valid), 32'h0);

    do_reset();
    out_ready = 4'b0001;
    send(2'd0, 8'h11);
    send(2'd0, 8'h22);
    send(2'd0, 8'h33);
    idle();
    tick(1);
    out_ready = 4'b0000;
    send(2'd0, 8'h44);
    send(2'd2, 8'h55);
    idle();
    check("mid_cnt0", 32'(cnt_0), 32'h3);
    check("mid_valid", 32'(out_valid), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_outs", {out_0, out_1, out_2, out_3}, 32'h0);
    check("arst_cnt0", 32'(cnt_0), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h0);
    clear_model();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'd0, 8'h4A);
    idle();
    check("post_valid", 32'(out_valid), 32'h1);
    check("post_out0", 32'(out_0), 32'h4A);

    w_out_ready = 4'b0010;
    w_in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w_in_data = 8'(i);
      tick(1);
    end
    w_in_valid = 1'b0;
    tick(1);
    check("wrap_cnt1", 32'(w_cnt_1), 32'h1);
    check("wrap_valid", 32'(w_out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
